// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART-driven ALU loader: receiver state encoding,
// oversampling ratio and the slot-to-load-strobe mapping.
package alu_uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int HALF_BIT   = OVERSAMPLE / 2;
   localparam int MAX_SLOTS  = 8;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // slot 0 -> operand 1, slot 1 -> operand 2, slot 2 -> opcode
   function automatic logic [MAX_SLOTS-1:0] slot_strobe(input logic [2:0] slot);
      logic [MAX_SLOTS-1:0] one;
      one = {{(MAX_SLOTS-1){1'b0}}, 1'b1};
      return one << slot;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style serial receiver with 16x oversampling. Emits a completed byte with
// a one-cycle valid or frame_err, plus the baud tick and an idle flag.
module uart_rx
   import alu_uart_pkg::*;
#(
   parameter int NB_DATA  = 8,
   parameter int BAUD_DIV = 54
)(
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] rx_byte,
   output logic               valid,
   output logic               frame_err,
   output logic               tick,
   output logic               idle
);

   localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   logic [1:0]         sync_q;
   logic               rx_s;
   logic               rx_d;
   logic [DIV_W-1:0]   div_cnt;
   rx_state_t          state, state_nxt;
   logic [OS_W-1:0]    os_cnt, os_cnt_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic [NB_DATA-1:0] shift_q, shift_nxt;

   assign rx_s    = sync_q[1];
   assign tick    = (div_cnt == DIV_W'(BAUD_DIV-1));
   assign idle    = (state == RX_IDLE);
   assign rx_byte = shift_q;

   // synchronizer and edge-detect history rest at the idle (mark) level
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync_q <= 2'b11;
         rx_d   <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], i_rx};
         rx_d   <= rx_s;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state   <= RX_IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shift_q <= '0;
      end else begin
         state   <= state_nxt;
         os_cnt  <= os_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift_q <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      os_cnt_nxt  = os_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_q;
      valid       = 1'b0;
      frame_err   = 1'b0;
      case (state)
         // a new falling edge is required, so a held-low line (break, or the
         // tail of an aborted frame) cannot retrigger reception
         RX_IDLE: begin
            if (rx_d && !rx_s) begin
               state_nxt  = RX_START;
               os_cnt_nxt = '0;
            end
         end
         RX_START: begin
            if (tick) begin
               if (os_cnt == OS_W'(HALF_BIT-1)) begin
                  os_cnt_nxt  = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  os_cnt_nxt = os_cnt + 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (os_cnt == OS_W'(OVERSAMPLE-1)) begin
                  os_cnt_nxt = '0;
                  shift_nxt  = {rx_s, shift_q[NB_DATA-1:1]};
                  if (bit_cnt == BIT_W'(NB_DATA-1)) state_nxt   = RX_STOP;
                  else                              bit_cnt_nxt = bit_cnt + 1'b1;
               end else begin
                  os_cnt_nxt = os_cnt + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (os_cnt == OS_W'(OVERSAMPLE-1)) begin
                  os_cnt_nxt = '0;
                  state_nxt  = RX_IDLE;
                  valid      = rx_s;
                  frame_err  = !rx_s;
               end else begin
                  os_cnt_nxt = os_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_alu_loader.sv
// Loads ALU operands/opcode from a UART stream: each good byte is presented on
// o_switches with a one-hot strobe selecting op1, op2, opcode in rotation.
module uart_alu_loader
   import alu_uart_pkg::*;
#(
   parameter int NB_DATA      = 8,
   parameter int N_PULSADORES = 3,
   parameter int BAUD_DIV     = 54,
   parameter int IDLE_BITS    = 32
)(
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_rx,
   output logic [NB_DATA-1:0]      o_switches,
   output logic [N_PULSADORES-1:0] o_pulsadores,
   output logic                    o_frame_err
);

   localparam int SLOT_W     = (N_PULSADORES > 1) ? $clog2(N_PULSADORES) : 1;
   localparam int IDLE_LIMIT = IDLE_BITS * OVERSAMPLE;
   localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

   logic [NB_DATA-1:0] rx_byte;
   logic               rx_valid;
   logic               rx_frame_err;
   logic               tick;
   logic               rx_idle;
   logic [SLOT_W-1:0]  slot;
   logic [IDLE_W-1:0]  idle_cnt;
   logic               idle_timeout;

   uart_rx #(
      .NB_DATA  (NB_DATA),
      .BAUD_DIV (BAUD_DIV)
   ) u_rx (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_rx      (i_rx),
      .rx_byte   (rx_byte),
      .valid     (rx_valid),
      .frame_err (rx_frame_err),
      .tick      (tick),
      .idle      (rx_idle)
   );

   assign idle_timeout = (idle_cnt == IDLE_W'(IDLE_LIMIT));

   // saturates at the limit so the slot stays cleared for the rest of the gap
   always_ff @(posedge i_clock) begin
      if (i_reset || !rx_idle)      idle_cnt <= '0;
      else if (tick && !idle_timeout) idle_cnt <= idle_cnt + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_switches   <= '0;
         o_pulsadores <= '0;
         o_frame_err  <= 1'b0;
         slot         <= '0;
      end else begin
         o_pulsadores <= '0;
         o_frame_err  <= rx_frame_err;
         if (rx_valid) begin
            o_switches   <= rx_byte;
            o_pulsadores <= N_PULSADORES'(slot_strobe(3'(slot)));
            slot         <= (slot == SLOT_W'(N_PULSADORES-1)) ? '0 : slot + 1'b1;
         end else if (idle_timeout) begin
            slot <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_alu_loader.sv
// Bench for uart_alu_loader: directed vector table, randomized frames against
// a slot/byte reference model, plus glitch and mid-frame reset sequences.
module tb_uart_alu_loader;

   localparam int NB_DATA   = 8;
   localparam int N_PULS    = 3;
   localparam int BAUD_DIV  = 2;
   localparam int IDLE_BITS = 32;
   localparam int BIT_CYC   = BAUD_DIV * 16;
   localparam int LONG_GAP  = 36;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] sw;
   logic [2:0] puls;
   logic       ferr;

   always #5 clk = ~clk;

   uart_alu_loader #(
      .NB_DATA      (NB_DATA),
      .N_PULSADORES (N_PULS),
      .BAUD_DIV     (BAUD_DIV),
      .IDLE_BITS    (IDLE_BITS)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_rx         (rx),
      .o_switches   (sw),
      .o_pulsadores (puls),
      .o_frame_err  (ferr)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] obs_puls[$];
   logic [7:0] obs_sw[$];
   int         obs_err   = 0;
   logic [2:0] prev_puls = 3'b000;
   logic       prev_err  = 1'b0;

   // reference model state: next slot index and last good byte
   int         m_slot = 0;
   logic [7:0] m_sw   = 8'h00;

   typedef struct {
      logic [7:0] data;
      bit         ok;
      int         gap;
      bit         es;
      logic [2:0] ep;
      logic [7:0] esw;
      bit         ee;
   } vec_t;

   vec_t tbl[14];

   // every strobe must be one-hot and last one cycle; errors likewise one cycle
   always @(negedge clk) begin
      if (puls != 3'b000) begin
         obs_puls.push_back(puls);
         obs_sw.push_back(sw);
         n_chk++;
         if (!$onehot(puls) || prev_puls != 3'b000) begin
            n_fail++;
            $display("FAIL strobe_shape: got %b (prev %b), required one-hot single-cycle", puls, prev_puls);
         end
      end
      if (ferr) begin
         obs_err++;
         n_chk++;
         if (prev_err) begin
            n_fail++;
            $display("FAIL frame_err_width: pulse longer than one cycle");
         end
      end
      prev_puls = puls;
      prev_err  = ferr;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit ok, input int gap);
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = ok;
      repeat (BIT_CYC) @(negedge clk);
      rx = 1'b1;
      repeat (gap * BIT_CYC) @(negedge clk);
   endtask

   task automatic expect_frame(input string nm, input bit es, input logic [2:0] ep,
                               input logic [7:0] esw, input bit ee);
      logic [2:0] p;
      logic [7:0] s;
      check({nm, " strobes"}, 32'(obs_puls.size()), es ? 32'd1 : 32'd0);
      if (obs_puls.size() != 0) begin
         p = obs_puls.pop_front();
         s = obs_sw.pop_front();
         check({nm, " puls"}, 32'(p), 32'(ep));
         check({nm, " sw_at_strobe"}, 32'(s), 32'(esw));
      end
      check({nm, " frame_err"}, 32'(obs_err), ee ? 32'd1 : 32'd0);
      check({nm, " sw_hold"}, 32'(sw), 32'(esw));
      obs_puls.delete();
      obs_sw.delete();
      obs_err = 0;
   endtask

   task automatic model_frame(input logic [7:0] d, input bit ok, input int gap,
                              output bit es, output logic [2:0] ep,
                              output logic [7:0] esw, output bit ee);
      es = ok;
      ee = !ok;
      ep = ok ? 3'(1 << m_slot) : 3'b000;
      if (ok) begin
         m_sw   = d;
         m_slot = (m_slot + 1) % N_PULS;
      end
      esw = m_sw;
      if (gap >= LONG_GAP) m_slot = 0;
   endtask

   task automatic send_and_model(input string nm, input logic [7:0] d, input bit ok, input int gap);
      bit         es, ee;
      logic [2:0] ep;
      logic [7:0] esw;
      model_frame(d, ok, gap, es, ep, esw, ee);
      send_frame(d, ok, gap);
      expect_frame(nm, es, ep, esw, ee);
   endtask

   initial begin
      logic [7:0] aa;
      logic [7:0] d;
      bit         ok;
      int         gap;

      tbl[0]  = '{8'h05, 1'b1,  2, 1'b1, 3'b001, 8'h05, 1'b0};
      tbl[1]  = '{8'hFD, 1'b1,  2, 1'b1, 3'b010, 8'hFD, 1'b0};
      tbl[2]  = '{8'h20, 1'b1,  2, 1'b1, 3'b100, 8'h20, 1'b0};
      tbl[3]  = '{8'h3C, 1'b0,  3, 1'b0, 3'b000, 8'h20, 1'b1};
      tbl[4]  = '{8'h11, 1'b1,  2, 1'b1, 3'b001, 8'h11, 1'b0};
      tbl[5]  = '{8'h01, 1'b1, 40, 1'b1, 3'b010, 8'h01, 1'b0};
      tbl[6]  = '{8'h02, 1'b1, 40, 1'b1, 3'b001, 8'h02, 1'b0};
      tbl[7]  = '{8'hA0, 1'b1,  0, 1'b1, 3'b001, 8'hA0, 1'b0};
      tbl[8]  = '{8'hA1, 1'b1,  0, 1'b1, 3'b010, 8'hA1, 1'b0};
      tbl[9]  = '{8'hA2, 1'b1,  0, 1'b1, 3'b100, 8'hA2, 1'b0};
      tbl[10] = '{8'hA3, 1'b1,  0, 1'b1, 3'b001, 8'hA3, 1'b0};
      tbl[11] = '{8'hA4, 1'b1,  0, 1'b1, 3'b010, 8'hA4, 1'b0};
      tbl[12] = '{8'hA5, 1'b1,  0, 1'b1, 3'b100, 8'hA5, 1'b0};
      tbl[13] = '{8'hA6, 1'b1, 40, 1'b1, 3'b001, 8'hA6, 1'b0};

      repeat (5) @(negedge clk);
      check("reset sw",   32'(sw),   32'd0);
      check("reset puls", 32'(puls), 32'd0);
      check("reset ferr", 32'(ferr), 32'd0);
      rst = 1'b0;
      repeat (2 * BIT_CYC) @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         send_frame(tbl[i].data, tbl[i].ok, tbl[i].gap);
         expect_frame($sformatf("vec%0d", i), tbl[i].es, tbl[i].ep, tbl[i].esw, tbl[i].ee);
      end
      m_slot = 0;
      m_sw   = 8'hA6;

      for (int i = 0; i < 24; i++) begin
         d  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 5) == 0) gap = $urandom_range(LONG_GAP, LONG_GAP + 4);
         else                           gap = ok ? $urandom_range(0, 4) : $urandom_range(2, 5);
         send_and_model($sformatf("rand%0d", i), d, ok, gap);
      end

      // short low glitch on an idle line must be rejected as a false start
      rx = 1'b0;
      repeat (4 * BAUD_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT_CYC) @(negedge clk);
      check("glitch strobes", 32'(obs_puls.size()), 32'd0);
      check("glitch ferr",    32'(obs_err),         32'd0);
      send_and_model("post_glitch", 8'h5A, 1'b1, 2);

      for (int k = 0; k < 3 && m_slot == 0; k++)
         send_and_model($sformatf("pre_rst%0d", k), 8'h33, 1'b1, 1);

      // reset pulse during the last data bit of 0xAA aborts the frame
      aa = 8'hAA;
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         rx = aa[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = aa[7];
      repeat (BIT_CYC / 2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst sw",   32'(sw),   32'd0);
      check("midrst puls", 32'(puls), 32'd0);
      check("midrst ferr", 32'(ferr), 32'd0);
      rst = 1'b0;
      repeat (BIT_CYC / 2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT_CYC) @(negedge clk);
      check("midrst strobes", 32'(obs_puls.size()), 32'd0);
      check("midrst errs",    32'(obs_err),         32'd0);
      check("midrst sw_after", 32'(sw),             32'd0);
      m_slot = 0;
      m_sw   = 8'h00;
      send_and_model("post_rst", 8'h55, 1'b1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_alu_loader.md
UART_ALU_LOADER -- requirements
Module: uart_alu_loader

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 8, meaning operand/opcode byte width, which is also the UART data bits per frame.
REQ-002 The module SHALL have parameter N_PULSADORES, default 3, meaning load-strobe vector width, one bit per target register.
REQ-003 The module SHALL have parameter BAUD_DIV, default 54, meaning i_clock cycles per 16x oversample tick (100 MHz, 115200 baud).
REQ-004 The module SHALL have parameter IDLE_BITS, default 32, meaning the idle-line bit times after which the byte slot returns to 0.
REQ-005 The module SHALL have port i_clock, input, 1 bit: system clock; all logic on the rising edge.
REQ-006 The module SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port i_rx, input, 1 bit: asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-008 The module SHALL have port o_switches, output, NB_DATA bits: last correctly received byte, same format as the switch bank.
REQ-009 The module SHALL have port o_pulsadores, output, N_PULSADORES bits: one-hot, single-cycle load strobe (001 = operand 1, 010 = operand 2, 100 = opcode).
REQ-010 The module SHALL have port o_frame_err, output, 1 bit: single-cycle pulse on a stop-bit error.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer before any use; the synchronized signal is named rx_s.
REQ-012 The tick counter SHALL count 0..BAUD_DIV-1 and emit a one-cycle tick on wrap; it runs freely and is not phase-aligned to frames.
REQ-013 The receive FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 In IDLE, rx_s=0 SHALL move the FSM to START with the tick count cleared.
REQ-015 In START, after 8 ticks, rx_s=0 SHALL move the FSM to DATA; rx_s=1 (false start) SHALL return it to IDLE with no output.
REQ-016 In DATA, the FSM SHALL sample rx_s every 16 ticks into a shift register, LSB first, for NB_DATA bits, then move to STOP.
REQ-017 In STOP, after 16 ticks, rx_s=1 SHALL cause a valid-byte event; rx_s=0 SHALL cause a frame-error event; either way the FSM returns to IDLE.
REQ-018 On a valid-byte event, o_switches SHALL load the byte and o_pulsadores SHALL equal 1<<slot for exactly one cycle, on the cycle after the stop sample.
REQ-019 o_switches SHALL be valid in the strobe cycle and SHALL hold until the next valid byte.
REQ-020 Slot SHALL be a 0..N_PULSADORES-1 counter that advances after each valid byte and wraps from 2 to 0 (op1, op2, opcode, op1, ...).
REQ-021 On a frame-error event, o_frame_err SHALL pulse for one cycle; o_switches, o_pulsadores and slot SHALL be unchanged, so the byte is discarded.
REQ-022 An idle counter SHALL count ticks while the FSM is in IDLE and clear on leaving IDLE.
REQ-023 When the idle count reaches IDLE_BITS*16, slot SHALL be cleared to 0; this resynchronizes partial command triples.
REQ-024 o_pulsadores SHALL never have more than one bit set and SHALL be 0 outside strobe cycles.
REQ-025 The module SHALL contain no combinational path from i_rx to any output.

Reset
REQ-026 While i_reset=1, o_switches SHALL be 0, o_pulsadores 0, o_frame_err 0, slot 0, FSM IDLE, and all counters 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, reception SHALL start only on a new falling edge.
REQ-028 The synchronizer flops SHALL reset to 1, the idle level.

Structure
REQ-029 Constants for the FSM state encoding, OVERSAMPLE=16 and the slot-to-strobe mapping SHALL live in a shared package, alu_uart_pkg.
REQ-030 Serial framing (REQ-011..017) SHALL be the sub-module uart_rx, emitting byte, valid and frame_err.
REQ-031 uart_alu_loader SHALL hold only the slot counter, the idle timeout and the output registers.

Verification
REQ-032 Send 0x05, 0xFD, 0x20 -> strobes 001 with o_switches=0x05, then 010 with 0xFD, then 100 with 0x20, each exactly one cycle.
REQ-033 Send a frame 0x3C with stop bit 0, then 0x11 -> one o_frame_err pulse, no strobe for 0x3C, then 001 with 0x11.
REQ-034 Drive a 0-glitch of 4 ticks on idle i_rx -> no strobe, no error, FSM back to IDLE.
REQ-035 Send 0x01, idle 40 bit times, send 0x02 -> 0x02 strobes 001 (slot reset).
REQ-036 Pulse i_reset during the DATA bits of 0xAA -> outputs 0, no strobe; the next 0x55 strobes 001.
REQ-037 Send 7 back-to-back bytes -> strobe pattern 001,010,100,001,010,100,001, never two bits set.
